// File: rtl/conv_image_loader_if.sv
// conv_image_loader_if: groups the pixel-stream input, threshold and the
// image-output handshake of conv_image_loader.
//   slave  : the loader side (consumes pixels, produces the image)
//   master : the environment side (produces pixels, consumes the image)
interface conv_image_loader_if #(
  parameter int PIX_W   = 8,
  parameter int IMG_DIM = 28
);
  logic                                  pix_valid;
  logic                                  pix_ready;
  logic [PIX_W-1:0]                      pix_data;
  logic                                  pix_last;
  logic [PIX_W-1:0]                      threshold;
  logic                                  img_valid;
  logic                                  img_ready;
  logic [0:IMG_DIM-1][0:IMG_DIM-1]       image;
  logic                                  frame_err;

  modport slave (
    input  pix_valid, pix_data, pix_last, threshold, img_ready,
    output pix_ready, img_valid, image, frame_err
  );

  modport master (
    output pix_valid, pix_data, pix_last, threshold, img_ready,
    input  pix_ready, img_valid, image, frame_err
  );
endinterface

// File: rtl/conv_image_loader.sv
// conv_image_loader: binarizes a raster-order 8-bit pixel stream against a
// per-frame threshold and assembles an IMG_DIM x IMG_DIM single-bit image,
// presented with a valid/ready handshake and held stable until accepted.
// Optional feature macro: CONV_IMG_DOUBLE_BUF_EN (ping-pong image banks so
// the next frame can fill while the previous one is held).
module conv_image_loader #(
  parameter int PIX_W   = 8,
  parameter int IMG_DIM = 28
) (
  input  logic                 clk,
  input  logic                 rst_n,
  conv_image_loader_if.slave   bus
);
  localparam int            CW   = $clog2(IMG_DIM);
  localparam logic [CW-1:0] LAST = CW'(IMG_DIM - 1);

  typedef logic [0:IMG_DIM-1][0:IMG_DIM-1] img_t;

  logic [CW-1:0]    row_q, row_d;
  logic [CW-1:0]    col_q, col_d;
  logic [PIX_W-1:0] thr_q, thr_d;
  logic             pix_ready_q, pix_ready_d;
  logic             img_valid_q, img_valid_d;
  logic             frame_err_q, frame_err_d;

  logic             xfer;
  logic             handoff;
  logic             first_pos;
  logic             last_pos;
  logic             pix_bit;
  logic             wr_en;
  logic             frame_done;

  assign xfer      = bus.pix_valid && pix_ready_q;
  assign handoff   = img_valid_q && bus.img_ready;
  assign first_pos = (row_q == '0) && (col_q == '0);
  assign last_pos  = (row_q == LAST) && (col_q == LAST);
  // The first pixel of a frame is compared against the live threshold,
  // which is the same value being latched for the rest of the frame.
  assign pix_bit   = bus.pix_data >= (first_pos ? bus.threshold : thr_q);

  // Raster position, threshold latch and framing-error detection
  always_comb begin
    row_d       = row_q;
    col_d       = col_q;
    thr_d       = thr_q;
    frame_err_d = 1'b0;
    wr_en       = 1'b0;
    frame_done  = 1'b0;
    if (xfer) begin
      if (first_pos) begin
        thr_d = bus.threshold;
      end
      if (last_pos) begin
        // Final position always completes the frame; a missing pix_last is
        // only reported.
        wr_en       = 1'b1;
        frame_done  = 1'b1;
        row_d       = '0;
        col_d       = '0;
        frame_err_d = !bus.pix_last;
      end else if (bus.pix_last) begin
        // Early end of frame: drop this pixel and restart the frame.
        row_d       = '0;
        col_d       = '0;
        frame_err_d = 1'b1;
      end else begin
        wr_en = 1'b1;
        if (col_q == LAST) begin
          col_d = '0;
          row_d = row_q + 1'b1;
        end else begin
          col_d = col_q + 1'b1;
        end
      end
    end
  end

  // Shared registers: counters, latched threshold, handshake outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_q       <= '0;
      col_q       <= '0;
      thr_q       <= '0;
      pix_ready_q <= 1'b1;
      img_valid_q <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      row_q       <= row_d;
      col_q       <= col_d;
      thr_q       <= thr_d;
      pix_ready_q <= pix_ready_d;
      img_valid_q <= img_valid_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign bus.pix_ready = pix_ready_q;
  assign bus.img_valid = img_valid_q;
  assign bus.frame_err = frame_err_q;

`ifdef CONV_IMG_DOUBLE_BUF_EN

  logic [1:0][0:IMG_DIM-1][0:IMG_DIM-1] bank_q, bank_d;
  logic [1:0]                           full_q, full_d;
  logic                                 wr_bank_q, wr_bank_d;
  logic                                 rd_bank_q, rd_bank_d;

  // Ping-pong bank bookkeeping: fill into wr_bank, present rd_bank.
  // Completion and handoff always touch different banks, because a bank
  // can only be held while the other one is the one filling.
  always_comb begin
    bank_d    = bank_q;
    full_d    = full_q;
    wr_bank_d = wr_bank_q;
    rd_bank_d = rd_bank_q;
    if (wr_en) begin
      bank_d[wr_bank_q][row_q][col_q] = pix_bit;
    end
    if (frame_done) begin
      full_d[wr_bank_q] = 1'b1;
      wr_bank_d         = ~wr_bank_q;
    end
    if (handoff) begin
      full_d[rd_bank_q] = 1'b0;
      rd_bank_d         = ~rd_bank_q;
    end
    img_valid_d = full_d[rd_bank_d];
    pix_ready_d = !full_d[wr_bank_d];
  end

  // Bank storage and pointers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bank_q    <= '0;
      full_q    <= '0;
      wr_bank_q <= 1'b0;
      rd_bank_q <= 1'b0;
    end else begin
      bank_q    <= bank_d;
      full_q    <= full_d;
      wr_bank_q <= wr_bank_d;
      rd_bank_q <= rd_bank_d;
    end
  end

  assign bus.image = bank_q[rd_bank_q];

`else

  typedef enum logic {FILL, HOLD} state_t;

  state_t state_q, state_d;
  img_t   image_q, image_d;

  // FILL/HOLD sequencing and in-place image update
  always_comb begin
    state_d = state_q;
    image_d = image_q;
    case (state_q)
      FILL: if (frame_done) state_d = HOLD;
      HOLD: if (handoff)    state_d = FILL;
      default:              state_d = FILL;
    endcase
    if (wr_en) begin
      image_d[row_q][col_q] = pix_bit;
    end
    pix_ready_d = (state_d == FILL);
    img_valid_d = (state_d == HOLD);
  end

  // State and image registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= FILL;
      image_q <= '0;
    end else begin
      state_q <= state_d;
      image_q <= image_d;
    end
  end

  assign bus.image = image_q;

`endif

endmodule

// File: tb/tb_conv_image_loader.sv
// tb_conv_image_loader: directed bench for conv_image_loader.
module tb_conv_image_loader;
  localparam int PIX_W   = 8;
  localparam int IMG_DIM = 28;
  localparam int NPIX    = IMG_DIM * IMG_DIM;

  typedef logic [0:IMG_DIM-1][0:IMG_DIM-1] img_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  conv_image_loader_if #(.PIX_W(PIX_W), .IMG_DIM(IMG_DIM)) bus ();

  conv_image_loader #(.PIX_W(PIX_W), .IMG_DIM(IMG_DIM)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int   checks = 0;
  int   errors = 0;
  int   timeouts = 0;
  int   stalls = 0;
  bit   early_valid = 1'b0;
  img_t exp_img;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_img(input string tag);
    int bad;
    bad = 0;
    for (int r = 0; r < IMG_DIM; r++)
      for (int c = 0; c < IMG_DIM; c++)
        if (bus.image[r][c] !== exp_img[r][c]) bad++;
    checks++;
    assert (bus.image === exp_img) else begin
      errors++;
      $error("FAIL %s observed_bad_bits=%0d expected_bad_bits=0", tag, bad);
    end
  endtask

  function automatic logic [7:0] pix_val(input int mode, input int r, input int c);
    case (mode)
      0:       return 8'((r + c) * 4);
      1:       return 8'hFF;
      2:       return 8'd128;
      default: return 8'(r * 3 + c * 7);
    endcase
  endfunction

  task automatic build_exp(input int mode, input int thr);
    for (int r = 0; r < IMG_DIM; r++)
      for (int c = 0; c < IMG_DIM; c++)
        exp_img[r][c] = (pix_val(mode, r, c) >= 8'(thr));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Send pixels 0..stop_at-1 of a frame; pix_last on index last_at.
  task automatic send_frame(input int mode, input int thr0, input int chg_at, input int thr1,
                            input int last_at, input int stop_at, input bit rnd);
    for (int i = 0; i < stop_at; i++) begin
      int  budget;
      bit  acc;
      bit  first_try;
      if (rnd) begin
        bus.pix_valid = 1'b0;
        repeat ($urandom_range(0, 2)) tick();
      end
      bus.threshold = 8'((i >= chg_at) ? thr1 : thr0);
      bus.pix_valid = 1'b1;
      bus.pix_data  = pix_val(mode, i / IMG_DIM, i % IMG_DIM);
      bus.pix_last  = (i == last_at);
      budget    = 200;
      first_try = 1'b1;
      do begin
        acc = bus.pix_ready;
        if (!acc && first_try) stalls++;
        first_try = 1'b0;
        tick();
        budget--;
      end while (!acc && budget > 0);
      if (!acc) timeouts++;
      if (i < NPIX - 1 && bus.img_valid) early_valid = 1'b1;
    end
    bus.pix_valid = 1'b0;
    bus.pix_last  = 1'b0;
  endtask

  task automatic do_handoff();
    bus.img_ready = 1'b1;
    tick();
    bus.img_ready = 1'b0;
  endtask

  initial begin
    bus.pix_valid = 1'b0;
    bus.pix_data  = '0;
    bus.pix_last  = 1'b0;
    bus.threshold = '0;
    bus.img_ready = 1'b0;

    // Reset state
    repeat (2) tick();
    check("rst_img_valid", 32'(bus.img_valid), 32'd0);
    check("rst_pix_ready", 32'(bus.pix_ready), 32'd1);
    check("rst_frame_err", 32'(bus.frame_err), 32'd0);
    exp_img = '0;
    check_img("rst_image");
    rst_n = 1'b1;
    tick();

    // Single frame, ramp pattern, threshold 100
    early_valid = 1'b0;
    send_frame(0, 100, NPIX, 0, NPIX - 1, NPIX, 1'b0);
    check("f1_early_valid", 32'(early_valid), 32'd0);
    check("f1_img_valid", 32'(bus.img_valid), 32'd1);
    check("f1_frame_err", 32'(bus.frame_err), 32'd0);
`ifdef CONV_IMG_DOUBLE_BUF_EN
    check("f1_pix_ready", 32'(bus.pix_ready), 32'd1);
`else
    check("f1_pix_ready", 32'(bus.pix_ready), 32'd0);
`endif
    build_exp(0, 100);
    check_img("f1_image");
`ifndef CONV_IMG_DOUBLE_BUF_EN
    bus.pix_valid = 1'b1;
    bus.pix_data  = 8'h00;
`endif
    repeat (50) tick();
    bus.pix_valid = 1'b0;
    check("f1_hold_valid", 32'(bus.img_valid), 32'd1);
    check_img("f1_hold_image");

    // Handoff, then all-255 frame
    do_handoff();
    check("ho_img_valid", 32'(bus.img_valid), 32'd0);
    check("ho_pix_ready", 32'(bus.pix_ready), 32'd1);
    send_frame(1, 100, NPIX, 0, NPIX - 1, NPIX, 1'b0);
    check("f2_img_valid", 32'(bus.img_valid), 32'd1);
    build_exp(1, 100);
    check_img("f2_image");
    do_handoff();

    // Early pix_last on pixel 300, then a clean frame
    send_frame(1, 100, NPIX, 0, 300, 301, 1'b0);
    check("early_frame_err", 32'(bus.frame_err), 32'd1);
    check("early_img_valid", 32'(bus.img_valid), 32'd0);
    tick();
    check("early_err_pulse", 32'(bus.frame_err), 32'd0);
    send_frame(3, 128, NPIX, 0, NPIX - 1, NPIX, 1'b0);
    check("early_next_valid", 32'(bus.img_valid), 32'd1);
    check("early_next_err", 32'(bus.frame_err), 32'd0);
    build_exp(3, 128);
    check_img("early_next_image");
    do_handoff();

    // Missing pix_last: completes, error coincides with img_valid
    send_frame(0, 60, NPIX, 0, -1, NPIX, 1'b0);
    check("miss_img_valid", 32'(bus.img_valid), 32'd1);
    check("miss_frame_err", 32'(bus.frame_err), 32'd1);
    tick();
    check("miss_err_pulse", 32'(bus.frame_err), 32'd0);
    build_exp(0, 60);
    check_img("miss_image");
    do_handoff();

    // Threshold latch with random pix_valid gaps
    early_valid = 1'b0;
    timeouts    = 0;
    send_frame(2, 128, 10, 200, NPIX - 1, NPIX, 1'b1);
    check("thr_early_valid", 32'(early_valid), 32'd0);
    check("thr_img_valid", 32'(bus.img_valid), 32'd1);
    check("thr_timeouts", 32'(timeouts), 32'd0);
    exp_img = '1;
    check_img("thr_image");
    do_handoff();

    // Asynchronous reset at pixel 500, then a fresh frame
    send_frame(3, 128, NPIX, 0, NPIX - 1, 500, 1'b0);
    rst_n = 1'b0;
    #2;
    check("arst_img_valid", 32'(bus.img_valid), 32'd0);
    check("arst_pix_ready", 32'(bus.pix_ready), 32'd1);
    check("arst_frame_err", 32'(bus.frame_err), 32'd0);
    exp_img = '0;
    check_img("arst_image");
    #3;
    rst_n = 1'b1;
    tick();
    send_frame(0, 100, NPIX, 0, NPIX - 1, NPIX, 1'b0);
    check("arst_next_valid", 32'(bus.img_valid), 32'd1);
    build_exp(0, 100);
    check_img("arst_next_image");
    do_handoff();

`ifdef CONV_IMG_DOUBLE_BUF_EN
    // Two back-to-back frames with img_ready held low
    send_frame(1, 100, NPIX, 0, NPIX - 1, NPIX, 1'b0);
    check("db_f1_pix_ready", 32'(bus.pix_ready), 32'd1);
    stalls = 0;
    send_frame(0, 100, NPIX, 0, NPIX - 1, NPIX, 1'b0);
    check("db_f2_stalls", 32'(stalls), 32'd0);
    check("db_f2_pix_ready", 32'(bus.pix_ready), 32'd0);
    check("db_f2_img_valid", 32'(bus.img_valid), 32'd1);
    exp_img = '1;
    check_img("db_first_image");
    do_handoff();
    check("db_ho_img_valid", 32'(bus.img_valid), 32'd1);
    check("db_ho_pix_ready", 32'(bus.pix_ready), 32'd1);
    build_exp(0, 100);
    check_img("db_second_image");
    do_handoff();
    check("db_ho2_img_valid", 32'(bus.img_valid), 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
